// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer: id width default, entry kinds and field widths.
package reorder_buffer_pkg;

    localparam int ROB_WIDTH_DEF = 4;
    localparam int DEST_W        = 5;
    localparam int DATA_W        = 32;

    typedef enum logic [1:0] {
        ENTRY_REG    = 2'b00,
        ENTRY_BRANCH = 2'b01,
        ENTRY_STORE  = 2'b10
    } entry_type_e;

    // The unused issue encoding 2'b11 behaves as a plain register write.
    function automatic entry_type_e decode_type(input logic [1:0] raw);
        case (raw)
            2'b01:   return ENTRY_BRANCH;
            2'b10:   return ENTRY_STORE;
            default: return ENTRY_REG;
        endcase
    endfunction

endpackage

// File: rtl/rob_entry_array.sv
// Reorder buffer entry storage: allocation, CDB writeback, retire/flush clearing,
// head read-out and two combinational operand lookup ports with CDB bypass.
module rob_entry_array
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_WIDTH = ROB_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_en,
    input  logic [ROB_WIDTH-1:0] alloc_id,
    input  logic [1:0]           alloc_kind,
    input  logic [DEST_W-1:0]    alloc_dest,
    input  logic                 alloc_pred,
    input  logic                 cdb_valid,
    input  logic [ROB_WIDTH-1:0] cdb_id,
    input  logic [DATA_W-1:0]    cdb_value,
    input  logic                 cdb_taken,
    input  logic [DATA_W-1:0]    cdb_target,
    input  logic                 retire_en,
    input  logic [ROB_WIDTH-1:0] retire_id,
    input  logic                 flush,
    input  logic [ROB_WIDTH-1:0] head_id,
    output logic                 head_ready,
    output logic [1:0]           head_kind,
    output logic [DEST_W-1:0]    head_dest,
    output logic [DATA_W-1:0]    head_value,
    output logic                 head_pred,
    output logic                 head_taken,
    output logic [DATA_W-1:0]    head_target,
    input  logic [ROB_WIDTH-1:0] rs1_dep,
    output logic                 rs1_ready,
    output logic [DATA_W-1:0]    rs1_value,
    input  logic [ROB_WIDTH-1:0] rs2_dep,
    output logic                 rs2_ready,
    output logic [DATA_W-1:0]    rs2_value
);

    localparam int ROB_SIZE = 2 ** ROB_WIDTH;

    logic [ROB_SIZE-1:0] busy_q;
    logic [ROB_SIZE-1:0] ready_q;
    logic [1:0]          kind_q   [ROB_SIZE];
    logic [DEST_W-1:0]   dest_q   [ROB_SIZE];
    logic [DATA_W-1:0]   value_q  [ROB_SIZE];
    logic                pred_q   [ROB_SIZE];
    logic                taken_q  [ROB_SIZE];
    logic [DATA_W-1:0]   target_q [ROB_SIZE];

    logic cdb_hit;
    assign cdb_hit = cdb_valid && busy_q[cdb_id];

    // Update order matters: retire clears after writeback so a retired slot never keeps ready set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= '0;
            ready_q <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                kind_q[i]   <= '0;
                dest_q[i]   <= '0;
                value_q[i]  <= '0;
                pred_q[i]   <= 1'b0;
                taken_q[i]  <= 1'b0;
                target_q[i] <= '0;
            end
        end else if (flush) begin
            busy_q  <= '0;
            ready_q <= '0;
        end else begin
            if (cdb_hit) begin
                ready_q[cdb_id]  <= 1'b1;
                value_q[cdb_id]  <= cdb_value;
                taken_q[cdb_id]  <= cdb_taken;
                target_q[cdb_id] <= cdb_target;
            end
            if (retire_en) begin
                busy_q[retire_id]  <= 1'b0;
                ready_q[retire_id] <= 1'b0;
            end
            if (alloc_en) begin
                busy_q[alloc_id]  <= 1'b1;
                ready_q[alloc_id] <= 1'b0;
                kind_q[alloc_id]  <= alloc_kind;
                dest_q[alloc_id]  <= alloc_dest;
                pred_q[alloc_id]  <= alloc_pred;
            end
        end
    end

    assign head_ready  = ready_q[head_id];
    assign head_kind   = kind_q[head_id];
    assign head_dest   = dest_q[head_id];
    assign head_value  = value_q[head_id];
    assign head_pred   = pred_q[head_id];
    assign head_taken  = taken_q[head_id];
    assign head_target = target_q[head_id];

    logic rs1_bypass;
    logic rs2_bypass;
    assign rs1_bypass = cdb_valid && (cdb_id == rs1_dep);
    assign rs2_bypass = cdb_valid && (cdb_id == rs2_dep);

    assign rs1_ready = ready_q[rs1_dep] || rs1_bypass;
    assign rs1_value = rs1_bypass ? cdb_value : value_q[rs1_dep];
    assign rs2_ready = ready_q[rs2_dep] || rs2_bypass;
    assign rs2_value = rs2_bypass ? cdb_value : value_q[rs2_dep];

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocation and retirement, registered commit/flush pulses,
// branch mispredict recovery at commit.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_WIDTH = ROB_WIDTH_DEF
) (
    input  logic                 clockIn,
    input  logic                 resetIn,
    input  logic                 issueValid,
    input  logic [1:0]           issueType,
    input  logic [4:0]           issueDest,
    input  logic                 issuePredTaken,
    output logic                 robFull,
    output logic [ROB_WIDTH-1:0] issueRobId,
    input  logic                 cdbValid,
    input  logic [ROB_WIDTH-1:0] cdbRobId,
    input  logic [31:0]          cdbValue,
    input  logic                 cdbTaken,
    input  logic [31:0]          cdbTarget,
    output logic                 regUpdateValid,
    output logic [4:0]           regUpdateDest,
    output logic [31:0]          regUpdateValue,
    output logic [ROB_WIDTH-1:0] regUpdateRobId,
    output logic                 storeCommitValid,
    output logic [ROB_WIDTH-1:0] storeCommitRobId,
    output logic                 clearOut,
    output logic [31:0]          clearPcOut,
    input  logic [ROB_WIDTH-1:0] robRs1Dep,
    output logic                 robRs1Ready,
    output logic [31:0]          robRs1Value,
    input  logic [ROB_WIDTH-1:0] robRs2Dep,
    output logic                 robRs2Ready,
    output logic [31:0]          robRs2Value
);

    localparam int ROB_SIZE = 2 ** ROB_WIDTH;
    localparam logic [ROB_WIDTH:0] FULL_COUNT = (ROB_WIDTH + 1)'(ROB_SIZE);

    logic [ROB_WIDTH-1:0] head;
    logic [ROB_WIDTH-1:0] tail;
    logic [ROB_WIDTH:0]   count;
    logic [ROB_WIDTH:0]   count_next;

    logic              head_ready;
    logic [1:0]        head_kind;
    logic [DEST_W-1:0] head_dest;
    logic [DATA_W-1:0] head_value;
    logic              head_pred;
    logic              head_taken;
    logic [DATA_W-1:0] head_target;
    logic [1:0]        alloc_kind;

    logic commit_fire;
    logic mispredict;
    logic issue_fire;

    assign alloc_kind  = decode_type(issueType);
    assign commit_fire = (count != '0) && head_ready;
    assign mispredict  = commit_fire && (head_kind == ENTRY_BRANCH) && (head_taken != head_pred);
    // robFull reflects the count before this cycle's commit; a flush discards any issue.
    assign issue_fire  = issueValid && !robFull && !mispredict;
    assign issueRobId  = tail;

    always_comb begin
        count_next = count;
        if (mispredict) begin
            count_next = '0;
        end else if (issue_fire && !commit_fire) begin
            count_next = count + 1'b1;
        end else if (!issue_fire && commit_fire) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clockIn or posedge resetIn) begin
        if (resetIn) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            robFull <= 1'b0;
        end else begin
            if (commit_fire) begin
                head <= head + 1'b1;
            end
            if (mispredict) begin
                tail <= head + 1'b1;
            end else if (issue_fire) begin
                tail <= tail + 1'b1;
            end
            count   <= count_next;
            robFull <= (count_next == FULL_COUNT);
        end
    end

    always_ff @(posedge clockIn or posedge resetIn) begin
        if (resetIn) begin
            regUpdateValid   <= 1'b0;
            regUpdateDest    <= '0;
            regUpdateValue   <= '0;
            regUpdateRobId   <= '0;
            storeCommitValid <= 1'b0;
            storeCommitRobId <= '0;
            clearOut         <= 1'b0;
            clearPcOut       <= '0;
        end else begin
            regUpdateValid   <= commit_fire && (head_kind == ENTRY_REG);
            storeCommitValid <= commit_fire && (head_kind == ENTRY_STORE);
            clearOut         <= mispredict;
            if (commit_fire && (head_kind == ENTRY_REG)) begin
                regUpdateDest  <= head_dest;
                regUpdateValue <= head_value;
                regUpdateRobId <= head;
            end
            if (commit_fire && (head_kind == ENTRY_STORE)) begin
                storeCommitRobId <= head;
            end
            if (mispredict) begin
                clearPcOut <= head_target;
            end
        end
    end

    rob_entry_array #(
        .ROB_WIDTH(ROB_WIDTH)
    ) entries (
        .clk         (clockIn),
        .rst         (resetIn),
        .alloc_en    (issue_fire),
        .alloc_id    (tail),
        .alloc_kind  (alloc_kind),
        .alloc_dest  (issueDest),
        .alloc_pred  (issuePredTaken),
        .cdb_valid   (cdbValid),
        .cdb_id      (cdbRobId),
        .cdb_value   (cdbValue),
        .cdb_taken   (cdbTaken),
        .cdb_target  (cdbTarget),
        .retire_en   (commit_fire),
        .retire_id   (head),
        .flush       (mispredict),
        .head_id     (head),
        .head_ready  (head_ready),
        .head_kind   (head_kind),
        .head_dest   (head_dest),
        .head_value  (head_value),
        .head_pred   (head_pred),
        .head_taken  (head_taken),
        .head_target (head_target),
        .rs1_dep     (robRs1Dep),
        .rs1_ready   (robRs1Ready),
        .rs1_value   (robRs1Value),
        .rs2_dep     (robRs2Dep),
        .rs2_ready   (robRs2Ready),
        .rs2_value   (robRs2Value)
    );

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: reset, commit path, full/wrap, ordering, flush and bypass.
module tb_reorder_buffer;

    logic        clockIn = 1'b0;
    logic        resetIn;
    logic        issueValid;
    logic [1:0]  issueType;
    logic [4:0]  issueDest;
    logic        issuePredTaken;
    logic        robFull;
    logic [3:0]  issueRobId;
    logic        cdbValid;
    logic [3:0]  cdbRobId;
    logic [31:0] cdbValue;
    logic        cdbTaken;
    logic [31:0] cdbTarget;
    logic        regUpdateValid;
    logic [4:0]  regUpdateDest;
    logic [31:0] regUpdateValue;
    logic [3:0]  regUpdateRobId;
    logic        storeCommitValid;
    logic [3:0]  storeCommitRobId;
    logic        clearOut;
    logic [31:0] clearPcOut;
    logic [3:0]  robRs1Dep;
    logic        robRs1Ready;
    logic [31:0] robRs1Value;
    logic [3:0]  robRs2Dep;
    logic        robRs2Ready;
    logic [31:0] robRs2Value;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    reorder_buffer dut (
        .clockIn          (clockIn),
        .resetIn          (resetIn),
        .issueValid       (issueValid),
        .issueType        (issueType),
        .issueDest        (issueDest),
        .issuePredTaken   (issuePredTaken),
        .robFull          (robFull),
        .issueRobId       (issueRobId),
        .cdbValid         (cdbValid),
        .cdbRobId         (cdbRobId),
        .cdbValue         (cdbValue),
        .cdbTaken         (cdbTaken),
        .cdbTarget        (cdbTarget),
        .regUpdateValid   (regUpdateValid),
        .regUpdateDest    (regUpdateDest),
        .regUpdateValue   (regUpdateValue),
        .regUpdateRobId   (regUpdateRobId),
        .storeCommitValid (storeCommitValid),
        .storeCommitRobId (storeCommitRobId),
        .clearOut         (clearOut),
        .clearPcOut       (clearPcOut),
        .robRs1Dep        (robRs1Dep),
        .robRs1Ready      (robRs1Ready),
        .robRs1Value      (robRs1Value),
        .robRs2Dep        (robRs2Dep),
        .robRs2Ready      (robRs2Ready),
        .robRs2Value      (robRs2Value)
    );

    always #5 clockIn = ~clockIn;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clockIn);
        #1;
    endtask

    task automatic issue(input logic [1:0] t, input logic [4:0] d, input logic p);
        issueValid     = 1'b1;
        issueType      = t;
        issueDest      = d;
        issuePredTaken = p;
        tick();
        issueValid     = 1'b0;
    endtask

    task automatic cdb(input logic [3:0] id, input logic [31:0] v, input logic tk, input logic [31:0] tg);
        cdbValid  = 1'b1;
        cdbRobId  = id;
        cdbValue  = v;
        cdbTaken  = tk;
        cdbTarget = tg;
        tick();
        cdbValid  = 1'b0;
    endtask

    task automatic do_reset();
        resetIn = 1'b1;
        #2;
        resetIn = 1'b0;
        tick();
    endtask

    initial begin
        resetIn = 1'b1;
        issueValid = 1'b0; issueType = 2'b00; issueDest = '0; issuePredTaken = 1'b0;
        cdbValid = 1'b0; cdbRobId = '0; cdbValue = '0; cdbTaken = 1'b0; cdbTarget = '0;
        robRs1Dep = '0; robRs2Dep = '0;
        repeat (2) @(posedge clockIn);
        #1;
        check_eq("rst_full", robFull, 0);
        check_eq("rst_tail", issueRobId, 0);
        check_eq("rst_reg_valid", regUpdateValid, 0);
        check_eq("rst_clear", clearOut, 0);
        check_eq("rst_rs1_ready", robRs1Ready, 0);
        check_eq("rst_rs1_value", robRs1Value, 0);
        resetIn = 1'b0;
        tick();

        // Single REG commit path
        issue(2'b00, 5'd5, 1'b0);
        check_eq("a_tail", issueRobId, 1);
        cdbValid = 1'b1; cdbRobId = 4'd0; cdbValue = 32'h1234;
        robRs1Dep = 4'd0;
        #1;
        check_eq("a_bypass_ready", robRs1Ready, 1);
        check_eq("a_bypass_value", robRs1Value, 32'h1234);
        tick();
        cdbValid = 1'b0;
        check_eq("a_no_early_commit", regUpdateValid, 0);
        tick();
        check_eq("a_reg_valid", regUpdateValid, 1);
        check_eq("a_reg_dest", regUpdateDest, 5);
        check_eq("a_reg_value", regUpdateValue, 32'h1234);
        check_eq("a_reg_id", regUpdateRobId, 0);
        tick();
        check_eq("a_pulse_end", regUpdateValid, 0);

        // Store commit, then asynchronous reset while the pulse is high
        issue(2'b10, 5'd0, 1'b0);
        issue(2'b00, 5'd3, 1'b0);
        issue(2'b00, 5'd4, 1'b0);
        check_eq("r_tail", issueRobId, 4);
        cdb(4'd1, 32'h0, 1'b0, 32'h0);
        tick();
        check_eq("r_store_valid", storeCommitValid, 1);
        check_eq("r_store_id", storeCommitRobId, 1);
        check_eq("r_store_no_reg", regUpdateValid, 0);
        #2;
        resetIn = 1'b1;
        #1;
        check_eq("r_async_full", robFull, 0);
        check_eq("r_async_tail", issueRobId, 0);
        check_eq("r_async_store", storeCommitValid, 0);
        check_eq("r_async_store_id", storeCommitRobId, 0);
        check_eq("r_async_reg", regUpdateValid, 0);
        check_eq("r_async_clear", clearOut, 0);
        resetIn = 1'b0;
        tick();

        // Out-of-order completion, in-order retirement, lookup bypass
        for (int i = 0; i < 4; i++) issue(2'b00, 5'(8 + i), 1'b0);
        robRs1Dep = 4'd3; robRs2Dep = 4'd2;
        cdbValid = 1'b1; cdbRobId = 4'd3; cdbValue = 32'd7;
        #1;
        check_eq("b_rs1_ready", robRs1Ready, 1);
        check_eq("b_rs1_value", robRs1Value, 7);
        check_eq("b_rs2_ready", robRs2Ready, 0);
        tick();
        cdbValid = 1'b0;
        #1;
        check_eq("b_rs1_stored_ready", robRs1Ready, 1);
        check_eq("b_rs1_stored_value", robRs1Value, 7);
        exp_q.push_back(32'h10);
        exp_q.push_back(32'h11);
        exp_q.push_back(32'h22);
        exp_q.push_back(32'h7);
        cdb(4'd2, 32'h22, 1'b0, 32'h0);
        cdb(4'd1, 32'h11, 1'b0, 32'h0);
        check_eq("o_wait_head", regUpdateValid, 0);
        cdb(4'd0, 32'h10, 1'b0, 32'h0);
        check_eq("o_wait_head2", regUpdateValid, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("o_valid", regUpdateValid, 1);
            check_eq("o_id", regUpdateRobId, 32'(i));
            check_eq("o_dest", regUpdateDest, 32'(8 + i));
            check_eq("o_value", regUpdateValue, exp_q.pop_front());
        end
        tick();
        check_eq("o_idle", regUpdateValid, 0);

        // Fill, overflow attempt, wrap with simultaneous issue and commit
        do_reset();
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check_eq("f_not_full_15", robFull, 0);
            issue((i == 1) ? 2'b11 : 2'b00, 5'(i), 1'b0);
        end
        check_eq("f_full", robFull, 1);
        check_eq("f_tail_wrap", issueRobId, 0);
        issue(2'b00, 5'd31, 1'b0);
        check_eq("f_17th_full", robFull, 1);
        check_eq("f_17th_tail", issueRobId, 0);
        cdb(4'd0, 32'hA0, 1'b0, 32'h0);
        cdbValid = 1'b1; cdbRobId = 4'd1; cdbValue = 32'hA1;
        tick();
        cdbValid = 1'b0;
        check_eq("f_c0_valid", regUpdateValid, 1);
        check_eq("f_c0_id", regUpdateRobId, 0);
        check_eq("f_c0_dest", regUpdateDest, 0);
        check_eq("f_c0_value", regUpdateValue, 32'hA0);
        check_eq("f_c0_full", robFull, 0);
        issue(2'b00, 5'd20, 1'b0);
        check_eq("f_c1_valid", regUpdateValid, 1);
        check_eq("f_c1_id", regUpdateRobId, 1);
        check_eq("f_c1_dest", regUpdateDest, 1);
        check_eq("f_c1_value", regUpdateValue, 32'hA1);
        check_eq("f_c1_full", robFull, 0);
        check_eq("f_c1_tail", issueRobId, 1);
        issue(2'b00, 5'd21, 1'b0);
        check_eq("f_refull", robFull, 1);
        check_eq("f_refull_tail", issueRobId, 2);

        // Correctly predicted branch retires silently
        do_reset();
        issue(2'b01, 5'd0, 1'b1);
        cdb(4'd0, 32'h0, 1'b1, 32'h200);
        tick();
        check_eq("p_no_clear", clearOut, 0);
        check_eq("p_no_reg", regUpdateValid, 0);
        check_eq("p_no_store", storeCommitValid, 0);

        // Mispredicted branch flushes younger entries and a same-cycle issue
        do_reset();
        issue(2'b01, 5'd0, 1'b0);
        issue(2'b00, 5'd7, 1'b0);
        cdb(4'd1, 32'h77, 1'b0, 32'h0);
        cdb(4'd0, 32'h0, 1'b1, 32'h100);
        issueValid = 1'b1; issueType = 2'b00; issueDest = 5'd9;
        tick();
        issueValid = 1'b0;
        check_eq("m_clear", clearOut, 1);
        check_eq("m_clear_pc", clearPcOut, 32'h100);
        check_eq("m_tail", issueRobId, 1);
        check_eq("m_no_reg", regUpdateValid, 0);
        check_eq("m_full", robFull, 0);
        robRs1Dep = 4'd1;
        #1;
        check_eq("m_rs1_flushed", robRs1Ready, 0);
        tick();
        check_eq("m_clear_end", clearOut, 0);
        check_eq("m_id1_dead", regUpdateValid, 0);
        tick();
        check_eq("m_id1_dead2", regUpdateValid, 0);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check_eq("m_count_zero", robFull, 0);
            issue(2'b00, 5'd2, 1'b0);
        end
        check_eq("m_refill_full", robFull, 1);
        check_eq("m_refill_tail", issueRobId, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
